// File: rtl/t01_pkg.sv
// Shared definitions for the gravity-drop scheduler: global game-state
// encodings, the drop handshake FSM states and the level/speed defaults.
package t01_pkg;

   // Global top_level_state encodings; gravity runs only in TLS_PLAY.
   localparam logic [1:0] TLS_MENU  = 2'b00;
   localparam logic [1:0] TLS_PLAY  = 2'b01;
   localparam logic [1:0] TLS_PAUSE = 2'b10;
   localparam logic [1:0] TLS_OVER  = 2'b11;

   // Defaults for the scheduler and level counter.
   localparam int DEF_LINES_PER_LEVEL = 10;
   localparam int DEF_MAX_LEVEL       = 10;
   localparam int DEF_SPEED_STEP      = 1000000;
   localparam int DEF_MAX_PENDING     = 3;

   localparam logic [24:0] SCOREMOD_MAX = 25'h1FF_FFFF;

   // Drop request handshake states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      REQ  = 2'b10,
      GAP  = 2'b11
   } drop_state_t;

   // level*step clipped to the 25-bit divider input.
   function automatic logic [24:0] sat_scoremod(input logic [3:0] lvl, input int step);
      logic [63:0] prod;
      prod = 64'(lvl) * 64'(step);
      return (prod > 64'(SCOREMOD_MAX)) ? SCOREMOD_MAX : prod[24:0];
   endfunction

endpackage

// File: rtl/t01_level_ctr.sv
// Line accumulator and level counter. Clamps each lock's line count to 4,
// rolls the accumulator over every LINES_PER_LEVEL lines, bumps the level
// (saturating at MAX_LEVEL) and registers scoremod one cycle after level.
module t01_level_ctr
   import t01_pkg::*;
#(
   parameter int LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
   parameter int MAX_LEVEL       = DEF_MAX_LEVEL,
   parameter int SPEED_STEP      = DEF_SPEED_STEP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_game,
   input  logic        lines_valid,
   input  logic [2:0]  lines_cleared,
   output logic [3:0]  level,
   output logic [24:0] scoremod
);

   // Accumulator never exceeds LINES_PER_LEVEL-1+4 before the rollover.
   localparam int CW = $clog2(LINES_PER_LEVEL + 4);

   logic [CW-1:0] line_cnt;
   logic [2:0]    lines;
   logic [CW:0]   sum;

   assign lines = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
   assign sum   = {1'b0, line_cnt} + (CW+1)'(lines);

   // Accumulate cleared lines and advance the level on each rollover.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      if (rst) begin
         line_cnt <= '0;
         level    <= '0;
      end else if (new_game) begin
         line_cnt <= '0;
         level    <= '0;
      end else if (lines_valid) begin
         if (sum >= (CW+1)'(LINES_PER_LEVEL)) begin
            line_cnt <= CW'(sum - (CW+1)'(LINES_PER_LEVEL));
            if (level != 4'(MAX_LEVEL)) level <= level + 4'd1;
         end else begin
            line_cnt <= sum[CW-1:0];
         end
      end
   end

   // Register the divider speed value from the current level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           scoremod <= '0;
      else if (new_game) scoremod <= '0;
      else               scoremod <= sat_scoremod(level, SPEED_STEP);
   end

endmodule

// File: rtl/t01_drop_sched.sv
// Gravity drop scheduler. Turns the divider's active-low tick into a
// drop_req/drop_ack handshake toward the play FSM, feeds level/scoremod and
// the synchronized soft-drop speed_up back to the divider.
// Build option T01_TICK_QUEUE_EN: when defined, ticks arriving during a
// handshake are queued (up to MAX_PENDING) and a lost tick sets the sticky
// tick_overflow; when undefined such ticks are dropped and tick_overflow=0.
module t01_drop_sched
   import t01_pkg::*;
#(
   parameter logic [1:0] PLAY_STATE      = TLS_PLAY,
   parameter int         LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
   parameter int         MAX_LEVEL       = DEF_MAX_LEVEL,
   parameter int         SPEED_STEP      = DEF_SPEED_STEP,
   parameter int         MAX_PENDING     = DEF_MAX_PENDING
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_n,
   input  logic [1:0]  top_level_state,
   input  logic        new_game,
   input  logic        lines_valid,
   input  logic [2:0]  lines_cleared,
   input  logic        soft_drop,
   input  logic        drop_ack,
   output logic        drop_req,
   output logic        speed_up,
   output logic [24:0] scoremod,
   output logic [3:0]  level,
   output logic        tick_overflow
);

`ifdef T01_TICK_QUEUE_EN
   localparam bit QUEUE_EN = 1'b1;
`else
   localparam bit QUEUE_EN = 1'b0;
`endif

   localparam int PW = $clog2(MAX_PENDING + 1);

   drop_state_t   state_q, state_d;
   logic          tick_n_q, tick_r;
   logic          in_play;
   logic [PW-1:0] pending_q;
   logic          pend_inc, pend_dec, tick_lost;
   logic          sd_sync1, sd_sync2;

   assign in_play = (top_level_state == PLAY_STATE);

   // Detect the falling edge of tick_n and register it as a one-cycle tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_n_q <= 1'b1;
         tick_r   <= 1'b0;
      end else begin
         tick_n_q <= tick_n;
         tick_r   <= ~tick_n & tick_n_q;
      end
   end

   // Handshake FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic plus pending-queue increment/decrement requests.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d  = state_q;
      pend_inc = 1'b0;
      pend_dec = 1'b0;
      case (state_q)
         IDLE: if (in_play) state_d = WAIT;
         WAIT: begin
            if (tick_r) begin
               state_d = REQ;
            end else if (pending_q != '0) begin
               state_d  = REQ;
               pend_dec = 1'b1;
            end
         end
         REQ: begin
            pend_inc = tick_r;
            if (drop_ack) state_d = GAP;
         end
         GAP: begin
            pend_inc = tick_r;
            if (pending_q != '0) begin
               state_d  = REQ;
               pend_dec = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!in_play) state_d = IDLE;
   end

   assign drop_req  = (state_q == REQ);
   assign tick_lost = pend_inc && !pend_dec && (pending_q == PW'(MAX_PENDING));

   // Queued-tick counter; a simultaneous queue and dequeue cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else if (new_game || !in_play) begin
         pending_q <= '0;
      end else if (QUEUE_EN) begin
         if (pend_inc && !pend_dec) begin
            if (pending_q != PW'(MAX_PENDING)) pending_q <= pending_q + PW'(1);
         end else if (pend_dec && !pend_inc) begin
            pending_q <= pending_q - PW'(1);
         end
      end
   end

   // Sticky flag for a tick discarded at queue saturation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   tick_overflow <= 1'b0;
      else if (new_game)                         tick_overflow <= 1'b0;
      else if (QUEUE_EN && in_play && tick_lost) tick_overflow <= 1'b1;
   end

   // Two-flop synchronizer on soft_drop, then a registered play-state gate.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the first flop may go metastable; only sd_sync2 feeds logic.
      if (rst) begin
         sd_sync1 <= 1'b0;
         sd_sync2 <= 1'b0;
         speed_up <= 1'b0;
      end else begin
         sd_sync1 <= soft_drop;
         sd_sync2 <= sd_sync1;
         speed_up <= sd_sync2 & in_play;
      end
   end

   t01_level_ctr #(
      .LINES_PER_LEVEL (LINES_PER_LEVEL),
      .MAX_LEVEL       (MAX_LEVEL),
      .SPEED_STEP      (SPEED_STEP)
   ) u_level_ctr (
      .clk           (clk),
      .rst           (rst),
      .new_game      (new_game),
      .lines_valid   (lines_valid),
      .lines_cleared (lines_cleared),
      .level         (level),
      .scoremod      (scoremod)
   );

endmodule
